// File: rtl/fir_req_pkg.sv
// Shared constants for the FIR output requantizer.
// The constants describe the default N_DEF-bit instance; the top derives the same
// quantities from its own N and uses these values whenever N matches the default.
package fir_req_pkg;

    localparam int N_DEF = 16;
    localparam int IN_W  = 2 * N_DEF;
    localparam int MID_W = IN_W + 1;
    localparam int MAX_S = (2 ** (N_DEF - 1)) - 1;
    localparam int MIN_S = -(2 ** (N_DEF - 1));

endpackage

// File: rtl/fir_output_requantizer_if.sv
// Input sample stream and output valid/ready stream of the requantizer.
// The slave modport is the requantizer's view; the master modport is the view of
// the FIR core and downstream consumer combined.
interface fir_output_requantizer_if
    import fir_req_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int SHIFT_W = 5
);
    logic               in_valid;
    logic [2*N-1:0]     in_data;
    logic [SHIFT_W-1:0] shift;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       out_data;

    modport master (
        output in_valid, in_data, shift, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, shift, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/req_sync_fifo.sv
// Small synchronous FIFO with combinational head read.
// The caller only pushes when there is room or a pop happens in the same cycle.
// rdata reads as zero while empty so the output bus is quiet after reset.
module req_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_pop;

    // Status and head read.
    always_comb begin
        empty  = (level_q == '0);
        full   = (level_q == (AW + 1)'(DEPTH));
        do_pop = pop && !empty;
        level  = level_q;
        rdata  = empty ? '0 : mem[rd_ptr_q];
    end

    // Storage array; contents need no reset since reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, do_pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end
endmodule

// File: rtl/fir_output_requantizer.sv
// FIR output requantizer: round-half-up arithmetic right shift, saturation to N
// bits, FIFO buffering with a valid/ready output, and sticky saturate/overflow flags.
// Optional feature macro: REQ_SAT_CNT_EN adds the saturating sat_count output.
module fir_output_requantizer
    import fir_req_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DEPTH   = 4,
    parameter int SHIFT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    fir_output_requantizer_if.slave bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   sat_flag,
    output logic                   ovf_flag,
    input  logic                   clr_flags
`ifdef REQ_SAT_CNT_EN
    ,
    output logic [15:0]            sat_count
`endif
);
    // Package constants are the default-width values of these derived quantities.
    localparam int W0 = (N == N_DEF) ? IN_W : 2 * N;
    localparam int W1 = (N == N_DEF) ? MID_W : W0 + 1;
    localparam logic signed [W1-1:0] SAT_MAX = (N == N_DEF) ? W1'(MAX_S)
        : {{(W1 - N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [W1-1:0] SAT_MIN = (N == N_DEF) ? W1'(MIN_S)
        : {{(W1 - N + 1){1'b1}}, {(N - 1){1'b0}}};

    logic signed [W1-1:0] ext, rnd, rounded;
    logic                 s1_valid_q;
    logic signed [W1-1:0] s1_data_q;
    logic                 sat_hi, sat_lo, sat;
    logic [N-1:0]         s2_data;
    logic                 pop, wr_ok, drop, sat_evt;
    logic                 fifo_full, fifo_empty;
    logic [N-1:0]         fifo_rdata;
    logic                 sat_flag_q, ovf_flag_q;

    // Stage 1 datapath: sign-extend, add half an LSB of the result, shift.
    // One extra bit keeps the rounding add from wrapping at the positive limit.
    always_comb begin
        ext     = {bus.in_data[W0-1], bus.in_data};
        rnd     = (bus.shift != '0) ? (W1'(1) << (bus.shift - SHIFT_W'(1))) : '0;
        rounded = (ext + rnd) >>> bus.shift;
    end

    // Stage 1 register; shift only matters here, so later changes cannot touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data_q <= rounded;
            end
        end
    end

    // Stage 2: clamp, and decide whether the FIFO takes the sample this cycle.
    always_comb begin
        sat_hi  = (s1_data_q > SAT_MAX);
        sat_lo  = (s1_data_q < SAT_MIN);
        sat     = sat_hi || sat_lo;
        s2_data = sat_hi ? SAT_MAX[N-1:0] : (sat_lo ? SAT_MIN[N-1:0] : s1_data_q[N-1:0]);
        pop     = !fifo_empty && bus.out_ready;
        // A pop in the same cycle frees the slot even when full.
        wr_ok   = s1_valid_q && (!fifo_full || pop);
        drop    = s1_valid_q && !wr_ok;
        // Dropped samples never count as saturated.
        sat_evt = wr_ok && sat;
    end

    req_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (N)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_ok),
        .wdata (s2_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output stream straight from the FIFO head.
    always_comb begin
        bus.out_valid = !fifo_empty;
        bus.out_data  = fifo_rdata;
    end

    // Sticky flags; a set event in the clearing cycle wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag_q <= 1'b0;
            ovf_flag_q <= 1'b0;
        end else begin
            if (clr_flags) begin
                sat_flag_q <= 1'b0;
                ovf_flag_q <= 1'b0;
            end
            if (sat_evt) begin
                sat_flag_q <= 1'b1;
            end
            if (drop) begin
                ovf_flag_q <= 1'b1;
            end
        end
    end

    assign sat_flag = sat_flag_q;
    assign ovf_flag = ovf_flag_q;

`ifdef REQ_SAT_CNT_EN
    logic [15:0] sat_cnt_q;

    // Saturated-sample counter; stops at all-ones, clear plus increment gives 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else if (clr_flags) begin
            sat_cnt_q <= sat_evt ? 16'd1 : 16'd0;
        end else if (sat_evt && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_count = sat_cnt_q;
`endif
endmodule

// File: tb/tb_fir_output_requantizer.sv
// Directed self-checking bench for fir_output_requantizer (N=16, DEPTH=4, SHIFT_W=5).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_fir_output_requantizer;
    logic        clk;
    logic        rst;
    logic [2:0]  level;
    logic        sat_flag;
    logic        ovf_flag;
    logic        clr_flags;
`ifdef REQ_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    int checks = 0;
    int errors = 0;

    fir_output_requantizer_if #(.N(16), .SHIFT_W(5)) bus ();

    fir_output_requantizer #(
        .N       (16),
        .DEPTH   (4),
        .SHIFT_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .level     (level),
        .sat_flag  (sat_flag),
        .ovf_flag  (ovf_flag),
        .clr_flags (clr_flags)
`ifdef REQ_SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One-cycle sample; returns at the falling edge after capture.
    task automatic drive(input logic [31:0] d, input logic [4:0] s);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.shift    = s;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.shift    = 5'd31;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    logic [31:0] rv_d [9];
    logic [4:0]  rv_s [9];
    logic [15:0] rv_e [9];
    logic [15:0] ord4 [4];

    initial begin
        rv_d = '{32'd24, 32'hFFFF_FFE8, 32'd8, 32'hFFFF_FFF8, 32'd7, 32'd100,
                 32'hFFFF_FFFD, 32'h4000_0000, 32'h8000_0000};
        rv_s = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd0, 5'd1, 5'd31, 5'd31};
        rv_e = '{16'h0002, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0064,
                 16'hFFFF, 16'h0001, 16'hFFFF};

        rst           = 1'b1;
        clr_flags     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.shift     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        check("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
        check("rst_ovf_flag", {31'd0, ovf_flag}, 32'd0);
`ifdef REQ_SAT_CNT_EN
        check("rst_sat_count", {16'd0, sat_count}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Rounding and shift vectors, no backpressure.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(rv_d[i], rv_s[i]);
            check($sformatf("rnd%0d_lat", i), {31'd0, bus.out_valid}, 32'd0);
            @(negedge clk);
            check($sformatf("rnd%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("rnd%0d_data", i), {16'd0, bus.out_data}, {16'd0, rv_e[i]});
        end
        check("rnd_sat_flag", {31'd0, sat_flag}, 32'd0);

        // Saturation at shift 0.
        drive(32'h0010_0000, 5'd0);
        @(negedge clk);
        check("sat_pos_data", {16'd0, bus.out_data}, 32'h7FFF);
        check("sat_pos_flag", {31'd0, sat_flag}, 32'd1);
        drive(32'hFFF0_0000, 5'd0);
        @(negedge clk);
        check("sat_neg_data", {16'd0, bus.out_data}, 32'h8000);
        pulse_clr();
        check("sat_clr", {31'd0, sat_flag}, 32'd0);
        drive(32'h0000_7FFF, 5'd0);
        @(negedge clk);
        check("edge_max_data", {16'd0, bus.out_data}, 32'h7FFF);
        drive(32'hFFFF_8000, 5'd0);
        @(negedge clk);
        check("edge_min_data", {16'd0, bus.out_data}, 32'h8000);
        check("edge_no_sat", {31'd0, sat_flag}, 32'd0);
        drive(32'h0000_8000, 5'd0);
        @(negedge clk);
        check("edge_over_data", {16'd0, bus.out_data}, 32'h7FFF);
        check("edge_over_flag", {31'd0, sat_flag}, 32'd1);
        pulse_clr();
`ifdef REQ_SAT_CNT_EN
        check("cnt_cleared", {16'd0, sat_count}, 32'd0);
        drive(32'h0100_0000, 5'd0);
        drive(32'hFF00_0000, 5'd0);
        drive(32'h0000_8000, 5'd0);
        repeat (2) @(negedge clk);
        check("cnt_three", {16'd0, sat_count}, 32'd3);
        pulse_clr();
        check("cnt_clr", {16'd0, sat_count}, 32'd0);
`endif
        // Clear and set in the same cycle: set wins.
        drive(32'hFFFF_7FFF, 5'd0);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("setwins_data", {16'd0, bus.out_data}, 32'h8000);
        check("setwins_flag", {31'd0, sat_flag}, 32'd1);
`ifdef REQ_SAT_CNT_EN
        check("setwins_cnt", {16'd0, sat_count}, 32'd1);
`endif
        pulse_clr();
        check("setwins_clr", {31'd0, sat_flag}, 32'd0);

        // Overflow: six samples into a stalled four-entry FIFO.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(i);
            bus.shift    = 5'd0;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("ovf_level", {29'd0, level}, 32'd4);
        check("ovf_flag", {31'd0, ovf_flag}, 32'd1);
        check("ovf_no_sat", {31'd0, sat_flag}, 32'd0);
        check("ovf_head", {16'd0, bus.out_data}, 32'd1);
        @(negedge clk);
        check("ovf_head_stable", {16'd0, bus.out_data}, 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_drain%0d", i), {16'd0, bus.out_data}, 32'(i));
            @(negedge clk);
        end
        check("ovf_empty", {31'd0, bus.out_valid}, 32'd0);
        check("ovf_level0", {29'd0, level}, 32'd0);
        pulse_clr();
        check("ovf_clr", {31'd0, ovf_flag}, 32'd0);

        // Full FIFO with a pop in the same cycle as a write.
        bus.out_ready = 1'b0;
        ord4 = '{16'd2, 16'd3, 16'd4, 16'd7};
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (i == 4) ? 32'd7 : 32'(i + 1);
            bus.shift    = 5'd0;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        check("fullpop_pre_level", {29'd0, level}, 32'd4);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("fullpop_level", {29'd0, level}, 32'd4);
        check("fullpop_ovf", {31'd0, ovf_flag}, 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fullpop_drain%0d", i), {16'd0, bus.out_data}, {16'd0, ord4[i]});
            @(negedge clk);
        end
        check("fullpop_empty", {31'd0, bus.out_valid}, 32'd0);

        // Reset mid-stream: three in the FIFO, one in stage 1, one at the input.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (i == 0) ? 32'h0100_0000 : 32'(20 + i);
            bus.shift    = 5'd0;
            @(negedge clk);
        end
        bus.in_data = 32'd25;
        check("mid_pre_level", {29'd0, level}, 32'd3);
        check("mid_pre_sat", {31'd0, sat_flag}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_level", {29'd0, level}, 32'd0);
        check("mid_rst_flags", {30'd0, sat_flag, ovf_flag}, 32'd0);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("mid_quiet%0d", i), {31'd0, bus.out_valid}, 32'd0);
        end
        drive(32'd42, 5'd0);
        @(negedge clk);
        check("mid_new_valid", {31'd0, bus.out_valid}, 32'd1);
        check("mid_new_data", {16'd0, bus.out_data}, 32'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_output_requantizer.md
Name: fir_output_requantizer

Overview:
Consumer-side stage for the FIR datapath. It accepts the full-precision 2N-bit filter result and applies a programmable arithmetic right shift with round-half-up, then saturates the result to N bits. Results are buffered in a small FIFO and presented downstream on a valid/ready interface. The FIR core has no backpressure, so this block absorbs rate mismatch and flags any lost samples.

Parameters:
N, 16, output sample width; the input is 2N bits wide.
DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
SHIFT_W, 5, width of the shift control; the maximum shift is 2N-1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  in_data is a new sample this cycle.
in_data  input  2N  signed FIR result (the y_out sample).
shift  input  SHIFT_W  right-shift amount, captured together with in_data.
out_valid  output  1  FIFO head is valid.
out_ready  input  1  downstream accepts the head this cycle.
out_data  output  N  signed requantized sample at the FIFO head.
level  output  clog2(DEPTH)+1  FIFO occupancy.
sat_flag  output  1  sticky; set when any sample saturated.
ovf_flag  output  1  sticky; set when a sample was dropped because the FIFO was full.
clr_flags  input  1  synchronous clear of sat_flag and ovf_flag.

Behaviour:
- Reset: all pipeline valids = 0, FIFO empty, level=0, out_valid=0, out_data=0, sat_flag=0, ovf_flag=0.
- Stage 1, registered on the edge ending cycle c when in_valid=1:
  - sign-extend in_data to 2N+1 bits;
  - if shift>0, add 2^(shift-1);
  - arithmetic right shift by shift;
  - keep the 2N+1-bit result.
- Stage 2, registered on the edge ending cycle c+1:
  - saturate to [-2^(N-1), 2^(N-1)-1];
  - raise a sat indication if clamping occurred;
  - attempt the FIFO write.
- Latency: if the FIFO is empty, out_valid=1 with the sample in cycle c+2. Throughput is 1 sample per cycle.
- Pop: occurs on any edge where out_valid and out_ready are both 1. out_data always shows the head entry and is stable while out_valid=1 and out_ready=0.
- Write acceptance: a write succeeds if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle (simultaneous push and pop at full is legal; level stays DEPTH).
  - Otherwise the sample is discarded, ovf_flag is set and level is unchanged.
  - A discarded sample does not set sat_flag.
- Empty: out_valid=0 and out_ready is ignored. Simultaneous push and pop at empty is impossible, because a written entry is not visible until the next cycle.
- Pointers wrap modulo DEPTH.
- Flags: sat_flag and ovf_flag set on the edge of the event. If clr_flags and a set event fall in the same cycle, the set wins.
- Reset mid-stream: in-flight stage-1 and stage-2 samples and all FIFO contents are lost. No output is produced until a new in_valid arrives.
- The shift value is used only when it is captured with in_data; later changes do not affect samples already in flight.

Optional Feature:
REQ_SAT_CNT_EN
- Defined: adds output port sat_count [15:0], which increments once per saturated sample that is written and saturates at 16'hFFFF. It resets to 0 and is cleared by clr_flags. If a clear and an increment coincide, the result is 1.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Decomposition:
- Package fir_req_pkg: localparams for the default N, the input width (2N) and the intermediate width (2N+1), plus the saturation bound constants MAX_S and MIN_S.
- Sub-module req_sync_fifo (DEPTH, width N): push and pop ports, level output and full/empty outputs. The top-level module holds the round, shift, saturate pipeline and the flags.

Test Plan:
- Rounding, N=16, shift=4, no backpressure (out_ready=1): in_data=24 gives out_data=2, and in_data=-24 gives -1. Each appears 2 cycles after in_valid; sat_flag stays 0.
- Saturation, shift=0: in_data=32'h0010_0000 gives 16'h7FFF with sat_flag=1; in_data=32'hFFF0_0000 gives 16'h8000. After clr_flags, sat_flag=0.
- Overflow: hold out_ready=0 and drive 6 consecutive samples 1..6. Expect level=4 and ovf_flag=1; after releasing out_ready, outputs are 1,2,3,4 in order and samples 5 and 6 never appear.
- Full with simultaneous pop: fill to 4, then assert out_ready=1 for the same cycle a new sample 7 reaches stage 2. The write is accepted, level stays 4 and ovf_flag stays 0.
- Reset mid-stream: assert rst with 2 samples in flight and 3 in the FIFO. Expect out_valid=0, level=0 and flags 0 immediately; no stale output after rst is released.
- With REQ_SAT_CNT_EN defined: 3 saturating samples give sat_count=3, and clr_flags returns it to 0.
